// File: rtl/core_pkg.sv
// core_pkg: state, opcode and ALU-operation encodings for multicycle_core.
package core_pkg;

    // FSM states; the encoding is visible on dbg_state.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } t_state;

    // Instruction opcodes; 4'hB..4'hE are unassigned and execute as NOP.
    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_ADDI = 4'h6,
        OP_LI   = 4'h7,
        OP_BEQ  = 4'h8,
        OP_BLT  = 4'h9,
        OP_JMP  = 4'hA,
        OP_HALT = 4'hF
    } t_opcode;

    // ALU operations; ALU_PASSY forwards the second operand (used by LI).
    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_AND   = 3'd2,
        ALU_OR    = 3'd3,
        ALU_XOR   = 3'd4,
        ALU_PASSY = 3'd5
    } t_alu_op;

    localparam int OPW = 4;

    // Opcodes ADD..LI are exactly the ones that write the register file.
    function automatic logic writes_reg(input logic [OPW-1:0] op);
        return (op >= OP_ADD) && (op <= OP_LI);
    endfunction

endpackage

// File: rtl/defs_pkg.sv
// defs: shared definitions reused across the lab cores.
package defs;

    // Compare flags produced by the ALU.
    typedef struct packed {
        logic eq;   // x == y
        logic lt;   // x <  y, two's complement
        logic ltu;  // x <  y, unsigned
    } t_cmp;

endpackage

// File: rtl/core_alu.sv
// core_alu: combinational ALU plus compare flags, arithmetic modulo 2**DW.
module core_alu
    import core_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] x,
    input  logic [DW-1:0] y,
    input  t_alu_op       op,
    output logic [DW-1:0] f,
    output defs::t_cmp    cmp
);

    // Result selection by operation.
    always_comb begin
        // NOTE: default assignment first, so no path through the case leaves f unassigned (no latch).
        f = '0;
        case (op)
            ALU_ADD:   f = x + y;
            ALU_SUB:   f = x - y;
            ALU_AND:   f = x & y;
            ALU_OR:    f = x | y;
            ALU_XOR:   f = x ^ y;
            ALU_PASSY: f = y;
            default:   f = '0;
        endcase
    end

    assign cmp.eq  = (x == y);
    assign cmp.lt  = ($signed(x) < $signed(y));
    assign cmp.ltu = (x < y);

endmodule

// File: rtl/multicycle_core.sv
// multicycle_core: FETCH/DECODE/EXEC/WB core with a req/ready instruction
// port, run / single-step / halt control and debug taps.
module multicycle_core
    import core_pkg::*;
#(
    parameter  int DW   = 8,
    parameter  int NREG = 4,
    parameter  int PCW  = 6,
    parameter  int IMMW = 8,
    localparam int RAW  = $clog2(NREG),
    localparam int IW   = OPW + 3 * RAW + IMMW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            step,
    output logic            imem_req,
    output logic [PCW-1:0]  imem_addr,
    input  logic [IW-1:0]   imem_rdata,
    input  logic            imem_ready,
    output logic            halted,
    output logic            retire,
    output logic            wb_en,
    output logic [RAW-1:0]  wb_addr,
    output logic [DW-1:0]   wb_data,
    output logic [PCW-1:0]  dbg_pc,
    output logic [2:0]      dbg_state,
    input  logic [RAW-1:0]  dbg_raddr,
    output logic [DW-1:0]   dbg_rdata
);

    if (IMMW < PCW) begin : g_bad_immw
        $error("multicycle_core: IMMW (%0d) must be >= PCW (%0d)", IMMW, PCW);
    end
    if ((NREG < 2) || ((NREG & (NREG - 1)) != 0)) begin : g_bad_nreg
        $error("multicycle_core: NREG (%0d) must be a power of two >= 2", NREG);
    end

    t_state          state_q;
    logic [PCW-1:0]  pc_q;
    logic [IW-1:0]   ir_q;
    logic [DW-1:0]   a_q;
    logic [DW-1:0]   b_q;
    logic [DW-1:0]   y_q;
    defs::t_cmp      cmp_q;
    logic            step_q;
    logic            imem_req_q;
    logic            retire_q;
    logic            wb_en_q;
    logic            halted_q;
    logic [DW-1:0]   regs_q [NREG];

    // Instruction fields, MSB first: opcode | ra1 | ra2 | wa | imm.
    logic [OPW-1:0]  opcode;
    logic [RAW-1:0]  ra1;
    logic [RAW-1:0]  ra2;
    logic [RAW-1:0]  wa;
    logic [IMMW-1:0] imm;
    logic [DW-1:0]   imm_dw;
    logic [PCW-1:0]  br_target;

    assign opcode    = ir_q[IW-1 -: OPW];
    assign ra1       = ir_q[IMMW + 3*RAW - 1 -: RAW];
    assign ra2       = ir_q[IMMW + 2*RAW - 1 -: RAW];
    assign wa        = ir_q[IMMW + RAW - 1 -: RAW];
    assign imm       = ir_q[IMMW-1:0];
    assign imm_dw    = DW'(imm);
    assign br_target = imm[PCW-1:0];

    // ALU operation and second-operand select from the opcode.
    t_alu_op         alu_op;
    logic            use_imm;
    always_comb begin
        alu_op  = ALU_ADD;
        use_imm = 1'b0;
        case (opcode)
            OP_SUB:  alu_op = ALU_SUB;
            OP_AND:  alu_op = ALU_AND;
            OP_OR:   alu_op = ALU_OR;
            OP_XOR:  alu_op = ALU_XOR;
            OP_ADDI: use_imm = 1'b1;
            OP_LI: begin
                alu_op  = ALU_PASSY;
                use_imm = 1'b1;
            end
            default: ;
        endcase
    end

    logic [DW-1:0]   alu_y;
    logic [DW-1:0]   alu_f;
    defs::t_cmp      alu_cmp;

    assign alu_y = use_imm ? imm_dw : b_q;

    core_alu #(.DW(DW)) u_alu (
        .x   (a_q),
        .y   (alu_y),
        .op  (alu_op),
        .f   (alu_f),
        .cmp (alu_cmp)
    );

    logic take_branch;
    logic step_rise;
    logic cmp_unused;

    assign take_branch = (opcode == OP_JMP)
                      || ((opcode == OP_BEQ) && cmp_q.eq)
                      || ((opcode == OP_BLT) && cmp_q.lt);
    assign step_rise   = step && !step_q;
    // The unsigned flag is captured but no current opcode branches on it.
    assign cmp_unused  = cmp_q.ltu;

    // Instruction sequencer: state, pc, pipeline registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            y_q        <= '0;
            cmp_q      <= '0;
            step_q     <= 1'b0;
            imem_req_q <= 1'b0;
            retire_q   <= 1'b0;
            wb_en_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register here samples pre-edge values.
            step_q   <= step;
            retire_q <= 1'b0;
            wb_en_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (run || step_rise) begin
                        state_q    <= FETCH;
                        imem_req_q <= 1'b1;
                    end
                end
                FETCH: begin
                    if (imem_ready) begin
                        ir_q       <= imem_rdata;
                        imem_req_q <= 1'b0;
                        state_q    <= DECODE;
                    end
                end
                DECODE: begin
                    if (opcode == OP_HALT) begin
                        halted_q <= 1'b1;
                        state_q  <= HALT;
                    end else begin
                        a_q     <= regs_q[ra1];
                        b_q     <= regs_q[ra2];
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    y_q      <= alu_f;
                    cmp_q    <= alu_cmp;
                    retire_q <= 1'b1;
                    wb_en_q  <= writes_reg(opcode);
                    state_q  <= WB;
                end
                WB: begin
                    pc_q       <= take_branch ? br_target : pc_q + PCW'(1);
                    imem_req_q <= run;
                    state_q    <= run ? FETCH : IDLE;
                end
                HALT: state_q <= HALT;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Register file write port, active during WB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the register file is reset because its contents are visible on dbg_rdata.
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en_q) begin
            regs_q[wa] <= y_q;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign halted    = halted_q;
    assign retire    = retire_q;
    assign wb_en     = wb_en_q;
    assign wb_addr   = wa;
    assign wb_data   = y_q;
    assign dbg_pc    = pc_q;
    assign dbg_state = state_q;
    assign dbg_rdata = regs_q[dbg_raddr];

endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: directed and random program checks against an
// instruction-level reference model.
module tb_multicycle_core;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        step;
    logic        imem_req;
    logic [5:0]  imem_addr;
    logic [17:0] imem_rdata;
    logic        imem_ready;
    logic        halted;
    logic        retire;
    logic        wb_en;
    logic [1:0]  wb_addr;
    logic [7:0]  wb_data;
    logic [5:0]  dbg_pc;
    logic [2:0]  dbg_state;
    logic [1:0]  dbg_raddr;
    logic [7:0]  dbg_rdata;

    logic [17:0] mem [64];
    logic        ready_fix;
    logic        rnd_mode;
    logic        rnd_ready = 1'b1;

    // Reference model state
    logic [7:0]  m_regs [4];
    logic [5:0]  m_pc;

    int vectors = 0;
    int miscompares = 0;

    multicycle_core dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .step       (step),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .halted     (halted),
        .retire     (retire),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .dbg_pc     (dbg_pc),
        .dbg_state  (dbg_state),
        .dbg_raddr  (dbg_raddr),
        .dbg_rdata  (dbg_rdata)
    );

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr];
    assign imem_ready = rnd_mode ? rnd_ready : ready_fix;

    always @(negedge clk) rnd_ready <= ($urandom_range(0, 3) != 0);

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [17:0] enc(input logic [3:0] op, input logic [1:0] r1,
                                        input logic [1:0] r2, input logic [1:0] w,
                                        input logic [7:0] im);
        return {op, r1, r2, w, im};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = '0;
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
    endtask

    // Executes the instruction at m_pc on the model.
    task automatic model_exec(output logic e_en, output logic [1:0] e_addr,
                              output logic [7:0] e_data, output logic e_halt,
                              output logic [7:0] e_old);
        logic [17:0] ins;
        logic [3:0]  op;
        logic [7:0]  a, b, im;
        logic        taken;
        ins    = mem[m_pc];
        op     = ins[17:14];
        a      = m_regs[ins[13:12]];
        b      = m_regs[ins[11:10]];
        e_addr = ins[9:8];
        im     = ins[7:0];
        e_en   = 1'b0;
        e_data = 8'h00;
        e_halt = 1'b0;
        e_old  = m_regs[e_addr];
        taken  = 1'b0;
        case (op)
            4'h1: begin e_en = 1'b1; e_data = a + b;   end
            4'h2: begin e_en = 1'b1; e_data = a - b;   end
            4'h3: begin e_en = 1'b1; e_data = a & b;   end
            4'h4: begin e_en = 1'b1; e_data = a | b;   end
            4'h5: begin e_en = 1'b1; e_data = a ^ b;   end
            4'h6: begin e_en = 1'b1; e_data = a + im;  end
            4'h7: begin e_en = 1'b1; e_data = im;      end
            4'h8: taken = (a == b);
            4'h9: taken = ($signed(a) < $signed(b));
            4'hA: taken = 1'b1;
            4'hF: e_halt = 1'b1;
            default: ;
        endcase
        if (e_en) m_regs[e_addr] = e_data;
        if (!e_halt) m_pc = taken ? im[5:0] : m_pc + 6'd1;
    endtask

    // Waits for the next retire (or halt) and checks it against the model.
    task automatic expect_instr(input string tag, input int exp_wait);
        logic       e_en, e_halt;
        logic [1:0] e_addr;
        logic [7:0] e_data, e_old;
        int         n;
        model_exec(e_en, e_addr, e_data, e_halt, e_old);
        n = 0;
        while (retire !== 1'b1 && halted !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (e_halt) begin
            chk({tag, "_halted"}, halted, 1);
            chk({tag, "_pc"}, dbg_pc, m_pc);
            chk({tag, "_state"}, dbg_state, HALT);
        end else begin
            chk({tag, "_retire"}, retire, 1);
            if (exp_wait >= 0) chk({tag, "_latency"}, n, exp_wait);
            chk({tag, "_wb_en"}, wb_en, e_en);
            if (e_en) begin
                chk({tag, "_wb_addr"}, wb_addr, e_addr);
                chk({tag, "_wb_data"}, wb_data, e_data);
                dbg_raddr = e_addr;
                #1;
                chk({tag, "_rd_old"}, dbg_rdata, e_old);
            end
            @(negedge clk);
            chk({tag, "_pc"}, dbg_pc, m_pc);
            if (e_en) chk({tag, "_rd_new"}, dbg_rdata, e_data);
        end
    endtask

    initial begin
        int cnt;
        reset = 1'b1; run = 1'b0; step = 1'b0;
        ready_fix = 1'b1; rnd_mode = 1'b0; dbg_raddr = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[0]    = enc(OP_LI,   2'd0, 2'd0, 2'd1, 8'd5);
        mem[1]    = enc(OP_LI,   2'd0, 2'd0, 2'd2, 8'd250);
        mem[2]    = enc(OP_ADD,  2'd1, 2'd2, 2'd3, 8'd0);
        mem[3]    = enc(OP_ADDI, 2'd3, 2'd0, 2'd3, 8'd2);
        mem[4]    = enc(OP_LI,   2'd0, 2'd0, 2'd1, 8'h80);
        mem[5]    = enc(OP_LI,   2'd0, 2'd0, 2'd2, 8'h01);
        mem[6]    = enc(OP_BLT,  2'd1, 2'd2, 2'd0, 8'h10);
        mem[16]   = enc(OP_BEQ,  2'd1, 2'd2, 2'd0, 8'h20);
        mem[17]   = enc(OP_JMP,  2'd0, 2'd0, 2'd0, 8'h3F);
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_halted", halted, 0);
        chk("rst_retire", retire, 0);
        chk("rst_wb_en", wb_en, 0);
        chk("rst_wb_addr", wb_addr, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_dbg_pc", dbg_pc, 0);
        chk("rst_dbg_state", dbg_state, IDLE);
        chk("rst_dbg_rdata", dbg_rdata, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_no_run", dbg_state, IDLE);
        run = 1'b1;
        @(negedge clk);
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 0);

        // Arithmetic with wrap, then branches and pc wrap, in run mode
        expect_instr("li_r1", 3);
        expect_instr("li_r2", 3);
        expect_instr("add_r3", 3);
        dbg_raddr = 2'd3; #1;
        chk("r3_is_255", dbg_rdata, 255);
        expect_instr("addi_wrap", 3);
        dbg_raddr = 2'd3; #1;
        chk("r3_is_1", dbg_rdata, 1);
        expect_instr("li_r1_80", 3);
        expect_instr("li_r2_01", 3);
        expect_instr("blt_signed", 3);
        chk("blt_pc", dbg_pc, 6'h10);
        expect_instr("beq_not_taken", 3);
        chk("beq_pc", dbg_pc, 6'h11);
        expect_instr("jmp_63", 3);
        expect_instr("nop_wrap", 3);
        chk("wrap_pc", dbg_pc, 0);
        run = 1'b0;
        expect_instr("run_drop", 3);
        chk("run_drop_idle", dbg_state, IDLE);

        // Fetch wait states in single-step
        ready_fix = 1'b0;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            if (dbg_state === FETCH && retire === 1'b0) cnt++;
        end
        chk("wait_fetch_cycles", cnt, 4);
        ready_fix = 1'b1;
        expect_instr("wait_instr", 3);

        // Reset during a stalled fetch
        ready_fix = 1'b0;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        chk("stall_req", imem_req, 1);
        reset = 1'b1;
        #1;
        chk("async_req_drop", imem_req, 0);
        chk("async_pc", dbg_pc, 0);
        chk("async_state", dbg_state, IDLE);
        ready_fix = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("late_ready_idle", dbg_state, IDLE);
        chk("late_ready_pc", dbg_pc, 0);

        // Single-step: two pulses, then a long held step
        for (int k = 0; k < 2; k++) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            expect_instr("step_pulse", 3);
        end
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (retire) cnt++;
        end
        chk("step_stop_retires", cnt, 0);
        chk("step_stop_idle", dbg_state, IDLE);
        begin
            logic       d_en, d_halt;
            logic [1:0] d_addr;
            logic [7:0] d_data, d_old;
            model_exec(d_en, d_addr, d_data, d_halt, d_old);
        end
        cnt = 0;
        step = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (retire) cnt++;
        end
        step = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (retire) cnt++;
        end
        chk("step_held_retires", cnt, 1);
        chk("step_held_pc", dbg_pc, m_pc);

        // HALT at pc 3
        mem[3] = enc(OP_HALT, 2'd0, 2'd0, 2'd0, 8'd0);
        run = 1'b1;
        expect_instr("halt", -1);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (retire) cnt++;
        end
        run = 1'b0;
        repeat (2) begin
            step = 1'b1;
            repeat (2) begin @(negedge clk); if (retire) cnt++; end
            step = 1'b0;
            repeat (2) begin @(negedge clk); if (retire) cnt++; end
        end
        chk("halt_no_retire", cnt, 0);
        chk("halt_sticky", halted, 1);
        chk("halt_pc_held", dbg_pc, 3);
        reset = 1'b1;
        #1;
        chk("halt_reset_clear", halted, 0);
        chk("halt_reset_state", dbg_state, IDLE);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Random programs with random fetch wait states
        for (int i = 0; i < 64; i++) begin
            mem[i] = enc(4'($urandom_range(0, 14)), 2'($urandom), 2'($urandom),
                         2'($urandom), 8'($urandom));
        end
        rnd_mode = 1'b1;
        @(negedge clk);
        run = 1'b1;
        for (int i = 0; i < 80; i++) expect_instr("rnd", -1);
        run = 1'b0;
        expect_instr("rnd_last", -1);
        chk("rnd_end_idle", dbg_state, IDLE);
        rnd_mode = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
